// File: rtl/ballot_pkg.sv
// rtl/ballot_pkg.sv - shared state encoding, candidate indices and defaults for the ballot unit
package ballot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_SELECTED = 2'd2,
        ST_CAST     = 2'd3
    } state_t;

    localparam logic [1:0] CAND_A = 2'd0;
    localparam logic [1:0] CAND_B = 2'd1;
    localparam logic [1:0] CAND_C = 2'd2;
    localparam logic [1:0] CAND_D = 2'd3;

    localparam int CNT_W_DEFAULT = 21;

    // Bit i of the result is the vote line for candidate index i (a = bit 0).
    function automatic logic [3:0] cand_onehot(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0000;
        case (idx)
            CAND_A:  v = 4'b0001;
            CAND_B:  v = 4'b0010;
            CAND_C:  v = 4'b0100;
            default: v = 4'b1000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ballot_timer.sv
// rtl/ballot_timer.sv - reloadable session idle counter that flags the last allowed idle cycle
module ballot_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic run,
    output logic expired
);

    localparam int TW = 16;

    logic [TW-1:0] count;

    // The counter is held at zero while no session is open, so every session starts clean.
    always_ff @(posedge clk) begin
        if (!rst || reload || !run) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

    assign expired = run && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/ballot_unit.sv
// rtl/ballot_unit.sv - single-ballot voting session FSM with vote pulses, cast counter and idle timeout
module ballot_unit
    import ballot_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [1:0]       sel,
    input  logic             sel_valid,
    input  logic             confirm,
    input  logic             cancel,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic [1:0]       selected,
    output logic [CNT_W-1:0] cast_count,
    output logic             timeout
);

    state_t     state;
    state_t     state_nx;
    logic [1:0] selected_nx;
    logic [3:0] vote_nx;
    logic       timeout_nx;
    logic       reload;
    logic       run;
    logic       expired;

    assign run = (state == ST_ARMED) || (state == ST_SELECTED);

    ballot_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .reload  (reload),
        .run     (run),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Event priority in SELECTED: cancel, then confirm, then re-selection, then timeout.
    always_comb begin
        state_nx    = state;
        selected_nx = selected;
        vote_nx     = 4'b0000;
        timeout_nx  = 1'b0;
        reload      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_nx = ST_ARMED;
                    reload   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (sel_valid) begin
                    state_nx    = ST_SELECTED;
                    selected_nx = sel;
                    reload      = 1'b1;
                end else if (expired) begin
                    state_nx   = ST_IDLE;
                    timeout_nx = 1'b1;
                end
            end
            ST_SELECTED: begin
                if (cancel) begin
                    state_nx = ST_ARMED;
                    reload   = 1'b1;
                end else if (confirm) begin
                    state_nx = ST_CAST;
                    vote_nx  = cand_onehot(selected);
                end else if (sel_valid) begin
                    selected_nx = sel;
                    reload      = 1'b1;
                end else if (expired) begin
                    state_nx   = ST_IDLE;
                    timeout_nx = 1'b1;
                end
            end
            ST_CAST: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Vote lines are loaded on the edge that enters CAST, so they are high exactly while in CAST.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a          <= 1'b0;
            b          <= 1'b0;
            c          <= 1'b0;
            d          <= 1'b0;
            busy       <= 1'b0;
            selected   <= CAND_A;
            cast_count <= '0;
            timeout    <= 1'b0;
        end else begin
            a        <= vote_nx[0];
            b        <= vote_nx[1];
            c        <= vote_nx[2];
            d        <= vote_nx[3];
            busy     <= (state_nx != ST_IDLE);
            selected <= selected_nx;
            timeout  <= timeout_nx;
            if (state == ST_CAST) begin
                cast_count <= cast_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ballot_unit.sv
// tb/tb_ballot_unit.sv - randomized and directed session-level bench for ballot_unit
module tb_ballot_unit;

    localparam int CW = 3;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic          sel_valid = 1'b0;
    logic          confirm = 1'b0;
    logic          cancel = 1'b0;
    logic          a, b, c, d, busy, timeout;
    logic [1:0]    selected;
    logic [CW-1:0] cast_count;

    int n_vec = 0;
    int n_bad = 0;

    // Session-level model: 0 = no session, 1 = open without choice, 2 = choice held, 3 = vote out.
    int m_phase  = 0;
    int m_choice = 0;
    int m_pulse  = -1;
    int m_count  = 0;
    int m_idle   = 0;
    int m_to     = 0;

    ballot_unit #(
        .CNT_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .confirm    (confirm),
        .cancel     (cancel),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .busy       (busy),
        .selected   (selected),
        .cast_count (cast_count),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit ar, input int s, input bit sv, input bit cf, input bit cn);
        m_pulse = -1;
        m_to    = 0;
        if (!r) begin
            m_phase = 0; m_choice = 0; m_count = 0; m_idle = 0;
        end else if (m_phase == 3) begin
            m_count = (m_count + 1) % (1 << CW);
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (ar) begin
                m_phase = 1; m_idle = 0;
            end
        end else if (m_phase == 2 && cn) begin
            m_phase = 1; m_idle = 0;
        end else if (m_phase == 2 && cf) begin
            m_pulse = m_choice; m_phase = 3;
        end else if (sv) begin
            m_choice = s; m_phase = 2; m_idle = 0;
        end else if (m_idle == TO - 1) begin
            m_phase = 0; m_to = 1;
        end else begin
            m_idle++;
        end
    endtask

    task automatic step(input bit r, input bit ar, input logic [1:0] s, input bit sv, input bit cf, input bit cn);
        rst = r; arm = ar; sel = s; sel_valid = sv; confirm = cf; cancel = cn;
        @(posedge clk);
        model(r, ar, int'(s), sv, cf, cn);
        #1;
        check("votes", {d, c, b, a}, (m_pulse < 0) ? 0 : (1 << m_pulse));
        check("busy", busy, (m_phase != 0) ? 1 : 0);
        check("timeout", timeout, m_to);
        check("cast_count", cast_count, m_count);
        check("onehot", ($countones({a, b, c, d}) <= 1) ? 1 : 0, 1);
        if (m_phase == 2) check("selected", selected, m_choice);
    endtask

    task automatic idle();
        step(1, 0, 2'd0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 2'd0, 0, 0, 0);
        step(0, 1, 2'd3, 1, 1, 1);
        check("rst_all", {a, b, c, d, busy, timeout, selected, cast_count}, 0);

        // Basic cast of candidate C.
        step(1, 1, 2'd0, 0, 0, 0);
        step(1, 0, 2'd2, 1, 0, 0);
        step(1, 0, 2'd0, 0, 1, 0);
        check("basic_c", {d, c, b, a}, 4'b0100);
        idle();
        check("basic_busy", busy, 0);
        check("basic_count", cast_count, 1);

        // Re-select then confirm; then select, cancel, confirm.
        step(1, 1, 2'd0, 0, 0, 0);
        step(1, 0, 2'd0, 1, 0, 0);
        step(1, 0, 2'd3, 1, 0, 0);
        step(1, 0, 2'd0, 0, 1, 0);
        check("resel_d", {d, c, b, a}, 4'b1000);
        idle();
        step(1, 1, 2'd0, 0, 0, 0);
        step(1, 0, 2'd1, 1, 0, 0);
        step(1, 0, 2'd0, 0, 0, 1);
        step(1, 0, 2'd0, 0, 1, 0);
        check("cancel_nopulse", {d, c, b, a}, 0);
        check("cancel_armed", busy, 1);

        // Simultaneous events with B latched.
        step(1, 0, 2'd1, 1, 0, 0);
        step(1, 0, 2'd0, 0, 1, 1);
        check("cf_cn_nopulse", {d, c, b, a}, 0);
        check("cf_cn_armed", busy, 1);
        step(1, 0, 2'd1, 1, 0, 0);
        step(1, 0, 2'd0, 1, 1, 0);
        check("cf_sv_b", {d, c, b, a}, 4'b0010);
        idle();

        // Abandon after TO idle cycles; then an event exactly on the expiry cycle.
        step(1, 1, 2'd0, 0, 0, 0);
        repeat (TO) idle();
        check("to_pulse", timeout, 1);
        check("to_idle", busy, 0);
        check("to_count", cast_count, 3);
        step(1, 1, 2'd0, 0, 0, 0);
        repeat (TO - 1) idle();
        step(1, 0, 2'd3, 1, 0, 0);
        check("expiry_sel", {timeout, busy}, 2'b01);
        repeat (TO - 1) idle();
        step(1, 1, 2'd0, 0, 1, 0);
        check("expiry_cf", {timeout, d}, 2'b01);
        idle();

        // Wrap of the cast counter, with arm held during the session.
        step(0, 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < (1 << CW); i++) begin
            step(1, 1, 2'd0, 0, 0, 0);
            step(1, 1, 2'(i), 1, 0, 0);
            step(1, 1, 2'd0, 0, 1, 0);
            step(1, 1, 2'd0, 0, 0, 0);
        end
        check("wrap", cast_count, 0);

        // Reset while the vote pulse is out.
        step(1, 1, 2'd0, 0, 0, 0);
        step(1, 0, 2'd2, 1, 0, 0);
        step(1, 0, 2'd0, 0, 1, 0);
        step(0, 0, 2'd0, 0, 0, 0);
        check("rst_cast", {a, b, c, d, busy, timeout, selected, cast_count}, 0);
        idle();
        check("rst_cast_count", cast_count, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 99) < 20),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 10));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ballot_unit.md
BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 Parameter CNT_W, default 21: width of the ballot counter; matches the tally counter width.
REQ-002 Parameter TIMEOUT, default 1000: idle cycles allowed in ARMED/SELECTED before the session is abandoned; legal range 2..65535.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (rst=0 sampled at a rising clk edge resets).
REQ-005 arm  in  1  officer enable; opens one voting session.
REQ-006 sel  in  2  candidate index: 0=A, 1=B, 2=C, 3=D.
REQ-007 sel_valid  in  1  voter selection strobe; sel is sampled when this is high.
REQ-008 confirm  in  1  voter confirms the latched selection.
REQ-009 cancel  in  1  voter withdraws the current selection.
REQ-010 a, b, c, d  out  1 each  one-hot single-cycle vote pulses to the tally.
REQ-011 busy  out  1  high whenever the state is not IDLE.
REQ-012 selected  out  2  latched candidate index; valid only in SELECTED.
REQ-013 cast_count  out  CNT_W  total ballots cast since reset.
REQ-014 timeout  out  1  single-cycle pulse when a session is abandoned.

Function
REQ-015 The FSM SHALL have the states IDLE, ARMED, SELECTED and CAST; all outputs SHALL be registered.
REQ-016 IDLE: arm=1 -> ARMED; all other inputs are ignored.
REQ-017 ARMED: sel_valid=1 -> SELECTED, latching sel into selected; confirm alone is ignored.
REQ-018 SELECTED: sel_valid=1 re-latches sel and stays in SELECTED; confirm=1 -> CAST; cancel=1 -> ARMED.
REQ-019 Simultaneous events in SELECTED: cancel beats confirm; confirm plus sel_valid casts the previously latched index, and the new sel is discarded.
REQ-020 CAST: exactly one of a/b/c/d, the one matching selected, SHALL be high for exactly one cycle; the next state is IDLE unconditionally.
REQ-021 Latency: confirm sampled at edge k -> vote pulse high from edge k to edge k+1 -> cast_count increments at edge k+1.
REQ-022 At most one vote pulse SHALL occur per arm; a new arm is required for each subsequent ballot.
REQ-023 arm asserted outside IDLE SHALL be ignored and SHALL NOT restart the session.
REQ-024 The timer SHALL reload to 0 on entering ARMED and on every accepted sel_valid or cancel, and SHALL increment on every other cycle in ARMED/SELECTED.
REQ-025 When the timer reaches TIMEOUT-1 with no accepted event, the FSM SHALL go to IDLE and pulse timeout for one cycle; no vote pulse is produced.
REQ-026 An accepted event on the expiry cycle SHALL take priority over timeout.
REQ-027 cast_count SHALL wrap modulo 2^CNT_W: all-ones plus one gives 0.
REQ-028 a, b, c and d SHALL never be high simultaneously, and SHALL all be low outside CAST.

Reset
REQ-029 rst=0 at an edge SHALL force IDLE, a=b=c=d=0, busy=0, selected=0, cast_count=0, timeout=0 and the timer to 0, regardless of state.
REQ-030 Reset asserted in CAST SHALL suppress the pulse and the cast_count increment; a partially completed session is lost.

Structure
REQ-031 Package ballot_pkg SHALL hold the state encoding, the candidate index constants (CAND_A..CAND_D) and the CNT_W default.
REQ-032 Sub-module ballot_timer SHALL implement the reloadable timeout counter, with inputs clk, rst, reload and run and output expired.
REQ-033 The FSM, pulse decode and cast_count SHALL reside in ballot_unit.

Verification
REQ-034 Basic cast: reset; arm; sel=2 with sel_valid; confirm -> c high for exactly one cycle, cast_count=1, busy=0 one cycle after the pulse.
REQ-035 Re-select and cancel: select 0, re-select 3, confirm -> d pulses only; a second run with select 1, cancel, confirm -> no pulse, state ARMED.
REQ-036 Simultaneous inputs: with 1 latched, assert confirm+cancel together -> no pulse, state ARMED; then confirm+sel_valid(sel=0) together -> b pulses.
REQ-037 Timeout: TIMEOUT=4; arm, then no input -> timeout pulse on the 4th cycle in ARMED, IDLE, cast_count unchanged; event on the expiry cycle -> no timeout.
REQ-038 Wrap and reset: CNT_W=3; cast 8 ballots -> cast_count=0; rst=0 asserted during CAST -> no pulse, all outputs 0.
REQ-039 Throughout all scenarios: a+b+c+d<=1 every cycle; arm asserted while busy has no effect.
